sub_8bit_pipe: RTL and testbench

Two-stage pipelined 8-bit signed subtractor computing Diff = A − B as a 9-bit signed result that cannot overflow. It is the inverse-direction companion of the team's 4-bit carry-lookahead adder. Subtraction is done as A + ~B + 1, with the carry chain split by nibble across two register stages. Upstream and downstream connect through valid/ready handshakes, so the block drops into streaming datapaths with full backpressure support.

---
 rtl/sub_8bit_pipe_if.sv | 34 +++
 rtl/sub_8bit_pipe.sv | 73 +++++++
 tb/tb_sub_8bit_pipe.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sub_8bit_pipe_if.sv
// Streaming handshake bundle for the pipelined 8-bit subtractor.
// Upstream drives A/B/in_valid; downstream drives out_ready.
interface sub_8bit_pipe_if;
    logic [7:0] A;
    logic [7:0] B;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] Diff;
    logic       Zero;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output A,
        output B,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  Diff,
        input  Zero,
        input  out_valid
    );

    modport slave (
        input  A,
        input  B,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output Diff,
        output Zero,
        output out_valid
    );
endinterface

// File: rtl/sub_8bit_pipe.sv
// Two-stage signed 8-bit subtractor, Diff = A - B as 9-bit two's complement.
// Low nibble (with carry) is added in stage 1, sign-extended high nibble in stage 2.
module sub_8bit_pipe (
    input  logic           clk,
    input  logic           rst_n,
    sub_8bit_pipe_if.slave bus
);
    logic       s1_valid_q;
    logic [3:0] lo_q;
    logic       c4_q;
    logic [3:0] a_hi_q;
    logic [3:0] nb_hi_q;

    logic       out_valid_q;
    logic [8:0] diff_q;
    logic       zero_q;

    logic [7:0] nb;
    logic [4:0] lo_sum;
    logic [4:0] hi_sum;
    logic [8:0] diff_d;
    logic       s2_ready;
    logic       s1_adv;
    logic       accept;

    always_comb begin
        nb       = ~bus.B;
        lo_sum   = {1'b0, bus.A[3:0]} + {1'b0, nb[3:0]} + 5'd1;
        hi_sum   = {a_hi_q[3], a_hi_q} + {nb_hi_q[3], nb_hi_q} + {4'b0000, c4_q};
        diff_d   = {hi_sum, lo_q};
        s2_ready = !out_valid_q || bus.out_ready;
        s1_adv   = s1_valid_q && s2_ready;
        // in_ready depends only on state and out_ready, never on in_valid
        accept   = bus.in_valid && (!s1_valid_q || s2_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            lo_q       <= 4'h0;
            c4_q       <= 1'b0;
            a_hi_q     <= 4'h0;
            nb_hi_q    <= 4'h0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            lo_q       <= lo_sum[3:0];
            c4_q       <= lo_sum[4];
            a_hi_q     <= bus.A[7:4];
            nb_hi_q    <= nb[7:4];
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            diff_q      <= 9'h000;
            zero_q      <= 1'b0;
        end else if (s1_adv) begin
            out_valid_q <= 1'b1;
            diff_q      <= diff_d;
            zero_q      <= (diff_d == 9'h000);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = !s1_valid_q || s2_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.Diff      = diff_q;
    assign bus.Zero      = zero_q;
endmodule

// File: tb/tb_sub_8bit_pipe.sv
// Randomised scoreboard bench for sub_8bit_pipe; reference is sext(A) - sext(B).
module tb_sub_8bit_pipe;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    sub_8bit_pipe_if bus ();

    sub_8bit_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] exp_q[$];
    logic       hold_pending;
    logic [8:0] hold_diff;
    logic       hold_zero;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] ref_diff(input logic [7:0] a, input logic [7:0] b);
        int d;
        d = int'($signed(a)) - int'($signed(b));
        return d[8:0];
    endfunction

    // Scoreboard: inputs are stable at the falling edge, so any handshake seen here
    // is the transfer that happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_pending = 1'b0;
        end else begin
            chk("in_ready", 32'(bus.in_ready), 32'((exp_q.size() < 2) || bus.out_ready));
            if (hold_pending) begin
                chk("held_valid", 32'(bus.out_valid), 32'd1);
                chk("held_diff", 32'(bus.Diff), 32'(hold_diff));
                chk("held_zero", 32'(bus.Zero), 32'(hold_zero));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_output", 32'(bus.Diff), 32'h1ff_ffff);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("diff", 32'(bus.Diff), 32'(e));
                    chk("zero", 32'(bus.Zero), 32'(e == 9'h000));
                end
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_diff(bus.A, bus.B));
            hold_pending = bus.out_valid && !bus.out_ready;
            hold_diff    = bus.Diff;
            hold_zero    = bus.Zero;
        end
    end

    task automatic drain();
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0 && !bus.out_valid) break;
            @(posedge clk); #1;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Single pair into an empty pipe; result must appear exactly two edges after accept.
    task automatic check_one(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp);
        @(posedge clk); #1;
        bus.A         = a;
        bus.B         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.A        = $urandom();
        bus.B        = $urandom();
        chk("lat_early", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_diff", 32'(bus.Diff), 32'(exp));
        chk("lat_zero", 32'(bus.Zero), 32'(exp == 9'h000));
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec         = 0;
        n_miss        = 0;
        hold_pending  = 1'b0;
        rst_n         = 1'b1;
        bus.A         = 8'h00;
        bus.B         = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_diff", 32'(bus.Diff), 32'd0);
        chk("rst_zero", 32'(bus.Zero), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check_one(8'h7f, 8'h80, 9'h0ff);
        check_one(8'h80, 8'h7f, 9'h101);
        check_one(8'h10, 8'h01, 9'h00f);
        check_one(8'h05, 8'h05, 9'h000);
        check_one(8'h00, 8'h01, 9'h1ff);

        // Back-to-back streaming with downstream always ready
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            bus.A         = $urandom();
            bus.B         = $urandom();
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
            if (i >= 2) chk("stream_out_valid", 32'(bus.out_valid), 32'd1);
        end
        drain();

        // Backpressure: only two results fit while downstream stalls
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.A         = $urandom();
        bus.B         = $urandom();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.A = $urandom();
            bus.B = $urandom();
        end
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_held", 32'(exp_q.size()), 32'd2);
        bus.out_ready = 1'b1;
        #1 chk("bp_in_ready_comb", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain();

        // Random handshake toggling
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk); #1;
            bus.A         = $urandom();
            bus.B         = $urandom();
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        drain();

        // Reset with both stages full
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.A         = 8'h44;
        bus.B         = 8'h11;
        repeat (2) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_diff", 32'(bus.Diff), 32'd0);
        chk("mid_rst_zero", 32'(bus.Zero), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_one(8'h03, 8'h05, 9'h1fe);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
